// File: rtl/layer_mac_sched_if.sv
// Stream and ROM bus bundle for layer_mac_sched: activation input, weight ROM reads, result output.
// master = scheduler side, slave = surrounding fabric / ROM / downstream layer.
interface layer_mac_sched_if #(
  parameter int unsigned ROM_AW = 10
);
  logic              act_valid;
  logic [7:0]        act_data;
  logic              act_ready;
  logic              w_rd_en;
  logic [ROM_AW-1:0] w_addr;
  logic [7:0]        w_data;
  logic              out_valid;
  logic [7:0]        out_data;
  logic [7:0]        out_idx;
  logic              out_ready;

  modport master (
    input  act_valid, act_data, w_data, out_ready,
    output act_ready, w_rd_en, w_addr, out_valid, out_data, out_idx
  );

  modport slave (
    output act_valid, act_data, w_data, out_ready,
    input  act_ready, w_rd_en, w_addr, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/layer_mac_sched.sv
// Time-multiplexed fully-connected layer: one shared 8-bit MAC + ReLU walks every neuron's ROM row.
// Define SAT_ACC_EN for saturating product/accumulate; default build wraps modulo 2^8.
module layer_mac_sched #(
  parameter int unsigned NUM_INPUTS  = 15,
  parameter int unsigned NUM_NEURONS = 32,
  parameter int unsigned ROM_AW      = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  layer_mac_sched_if.master     bus,
  output logic                  busy,
  output logic                  layer_done
);

  localparam int unsigned       KW        = $clog2(NUM_INPUTS + 1);
  localparam logic [KW-1:0]     KLast     = KW'(NUM_INPUTS);
  localparam logic [KW-1:0]     CntLast   = KW'(NUM_INPUTS - 1);
  localparam logic [7:0]        NLast     = 8'(NUM_NEURONS - 1);
  localparam logic [ROM_AW-1:0] RowStride = ROM_AW'(NUM_INPUTS + 1);

  typedef enum logic [1:0] {StLoad, StFetch, StDrain, StEmit} state_e;

  state_e            state_q, state_d;
  logic [KW-1:0]     cnt_q, cnt_d;
  logic [KW-1:0]     k_q, k_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        acc_q, acc_d;
  logic [ROM_AW-1:0] row_q, row_d;
  logic              pend_q;
  logic [KW-1:0]     pend_k_q;
  logic [7:0]        act_buf_q [NUM_INPUTS];

  logic              act_fire;
  logic              is_bias;
  logic signed [7:0] a_sel, w_s, addend, acc_new;

  assign act_fire = bus.act_valid && bus.act_ready;
  assign is_bias  = (pend_k_q == KLast);
  assign a_sel    = is_bias ? 8'sd0 : act_buf_q[pend_k_q];
  assign w_s      = bus.w_data;

`ifdef SAT_ACC_EN
  logic signed [15:0] prod;
  logic signed [7:0]  prod_sat;
  logic signed [8:0]  sum;

  always_comb begin
    prod = a_sel * w_s;
    if (prod > 16'sd127)       prod_sat = 8'sd127;
    else if (prod < -16'sd128) prod_sat = -8'sd128;
    else                       prod_sat = prod[7:0];
    addend = is_bias ? w_s : prod_sat;
    sum    = {acc_q[7], acc_q} + {addend[7], addend};
    // Sign bits disagree only on overflow; sum[8] carries the true sign.
    if (sum[8] != sum[7]) acc_new = sum[8] ? -8'sd128 : 8'sd127;
    else                  acc_new = sum[7:0];
  end
`else
  logic signed [7:0] prod_lo;

  always_comb begin
    prod_lo = a_sel * w_s;
    addend  = is_bias ? w_s : prod_lo;
    acc_new = acc_q + addend;
  end
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    n_d           = n_q;
    acc_d         = acc_q;
    row_d         = row_q;
    bus.act_ready = 1'b0;
    bus.w_rd_en   = 1'b0;
    bus.w_addr    = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_idx   = '0;
    layer_done    = 1'b0;

    // ROM data for the read issued last cycle lands now.
    if (pend_q) acc_d = acc_new;

    unique case (state_q)
      StLoad: begin
        bus.act_ready = reset;
        if (act_fire) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StFetch;
            n_d     = '0;
            acc_d   = '0;
            row_d   = '0;
            k_d     = '0;
          end
        end
      end
      StFetch: begin
        bus.w_rd_en = 1'b1;
        bus.w_addr  = row_q + ROM_AW'(k_q);
        k_d         = k_q + 1'b1;
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StDrain;
        end
      end
      StDrain: state_d = StEmit;
      StEmit: begin
        bus.out_valid = 1'b1;
        bus.out_data  = acc_q[7] ? 8'd0 : acc_q;
        bus.out_idx   = n_q;
        if (bus.out_ready) begin
          if (n_q == NLast) begin
            layer_done = 1'b1;
            cnt_d      = '0;
            state_d    = StLoad;
          end else begin
            n_d     = n_q + 1'b1;
            acc_d   = '0;
            row_d   = row_q + RowStride;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign busy = (state_q != StLoad) || (cnt_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StLoad;
      cnt_q    <= '0;
      k_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      row_q    <= '0;
      pend_q   <= 1'b0;
      pend_k_q <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) act_buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      row_q    <= row_d;
      pend_q   <= (state_q == StFetch);
      pend_k_q <= k_q;
      if (act_fire) act_buf_q[cnt_q] <= bus.act_data;
    end
  end

endmodule

// File: tb/tb_layer_mac_sched.sv
// Directed bench: 3-input/2-neuron layer (stall, backpressure, back-to-back, mid-FETCH reset)
// plus a 1-input/1-neuron instance for the wrap/saturate boundary.
module tb_layer_mac_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy_a, done_a, busy_b, done_b;
  int   total = 0;
  int   bad = 0;
  int   done_cnt_a = 0;
  logic [7:0] rom_a [8];
  logic [7:0] rom_b [4];

  always #5 clk = ~clk;

  layer_mac_sched_if #(.ROM_AW(4)) ifa ();
  layer_mac_sched_if #(.ROM_AW(2)) ifb ();

  layer_mac_sched #(.NUM_INPUTS(3), .NUM_NEURONS(2), .ROM_AW(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a), .layer_done(done_a)
  );
  layer_mac_sched #(.NUM_INPUTS(1), .NUM_NEURONS(1), .ROM_AW(2)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b), .layer_done(done_b)
  );

  always @(posedge clk) begin
    if (ifa.w_rd_en) ifa.w_data <= rom_a[ifa.w_addr[2:0]];
    if (ifb.w_rd_en) ifb.w_data <= rom_b[ifb.w_addr];
    if (done_a) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input int gap);
    ifa.act_valid = 1'b1;
    ifa.act_data  = d;
    step();
    ifa.act_valid = 1'b0;
    ifa.act_data  = 8'h5A;
    for (int i = 0; i < gap; i++) begin
      step();
      check_eq("stall_rd_en", ifa.w_rd_en, 0);
      check_eq("stall_ready", ifa.act_ready, 1);
    end
  endtask

  task automatic wait_a(input string tag, input logic [7:0] idx, input logic [7:0] data);
    int cyc = 0;
    while (!ifa.out_valid && cyc < 60) begin
      step();
      cyc++;
    end
    check_eq({tag, "_lat"}, cyc, 5);
    check_eq({tag, "_idx"}, ifa.out_idx, idx);
    check_eq({tag, "_data"}, ifa.out_data, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b_act [2];
    logic [7:0] b_exp [2];
    int cyc;
    rom_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, 8'd0, 8'd0, 8'd0};
    rom_b = '{8'd2, 8'd0, 8'd0, 8'd0};
    b_act = '{8'd100, 8'd50};
`ifdef SAT_ACC_EN
    b_exp = '{8'd127, 8'd100};
`else
    b_exp = '{8'd0, 8'd100};
`endif
    ifa.act_valid = 1'b0; ifa.act_data = '0; ifa.out_ready = 1'b0; ifa.w_data = '0;
    ifb.act_valid = 1'b0; ifb.act_data = '0; ifb.out_ready = 1'b1; ifb.w_data = '0;

    repeat (2) step();
    check_eq("rst_act_ready", ifa.act_ready, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_out_valid", ifa.out_valid, 0);
    check_eq("rst_rd_en", ifa.w_rd_en, 0);
    reset = 1'b1;
    #1;
    check_eq("rel_act_ready", ifa.act_ready, 1);
    check_eq("rel_busy", busy_a, 0);

    // Stalled activation stream {1,1,1}; neuron 0 result held under backpressure.
    send_a(8'd1, 2);
    check_eq("busy_after_beat", busy_a, 1);
    send_a(8'd1, 2);
    send_a(8'd1, 0);
    check_eq("fetch_rd_en", ifa.w_rd_en, 1);
    check_eq("fetch_addr0", ifa.w_addr, 0);
    wait_a("l1n0", 8'd0, 8'd10);
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_valid", ifa.out_valid, 1);
      check_eq("bp_data", ifa.out_data, 10);
      check_eq("bp_idx", ifa.out_idx, 0);
      check_eq("bp_rd_en", ifa.w_rd_en, 0);
    end
    ifa.out_ready = 1'b1;
    #1;
    check_eq("n0_no_done", done_a, 0);
    step();
    check_eq("row1_addr", ifa.w_addr, 4);
    wait_a("l1n1", 8'd1, 8'd0);
    check_eq("l1_done", done_a, 1);

    // Next vector {-2,1,1} offered during the layer_done cycle.
    ifa.act_valid = 1'b1;
    ifa.act_data  = 8'hFE;
    #1;
    check_eq("done_cyc_ready", ifa.act_ready, 0);
    step();
    check_eq("post_done_ready", ifa.act_ready, 1);
    check_eq("post_done_busy", busy_a, 0);
    step();
    send_a(8'd1, 0);
    send_a(8'd1, 0);
    wait_a("l2n0", 8'd0, 8'd7);
    step();
    wait_a("l2n1", 8'd1, 8'd2);
    step();
    check_eq("done_count", done_cnt_a, 2);
    check_eq("idle_busy", busy_a, 0);

    // Reset pulse while k=1 is being issued.
    send_a(8'd1, 0);
    send_a(8'd1, 0);
    send_a(8'd1, 0);
    step();
    check_eq("mid_addr", ifa.w_addr, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_rd_en", ifa.w_rd_en, 0);
    check_eq("mid_rst_ready", ifa.act_ready, 0);
    check_eq("mid_rst_valid", ifa.out_valid, 0);
    check_eq("mid_rst_busy", busy_a, 0);
    step();
    reset = 1'b1;
    #1;
    check_eq("mid_rel_ready", ifa.act_ready, 1);
    check_eq("mid_rel_valid", ifa.out_valid, 0);
    send_a(8'hFE, 0);
    send_a(8'd1, 0);
    send_a(8'd1, 0);
    wait_a("l3n0", 8'd0, 8'd7);
    step();
    wait_a("l3n1", 8'd1, 8'd2);
    step();

    // Single-input instance: 100*2 overflows 8 bits, 50*2 does not.
    for (int v = 0; v < 2; v++) begin
      ifb.act_valid = 1'b1;
      ifb.act_data  = b_act[v];
      step();
      ifb.act_valid = 1'b0;
      cyc = 0;
      while (!ifb.out_valid && cyc < 60) begin
        step();
        cyc++;
      end
      check_eq("b_lat", cyc, 3);
      check_eq("b_idx", ifb.out_idx, 0);
      check_eq("b_data", ifb.out_data, b_exp[v]);
      check_eq("b_done", done_b, 1);
      step();
      check_eq("b_idle", busy_b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_mac_sched.md
Name: layer_mac_sched

Overview:
- Time-multiplexed scheduler for one fully-connected layer: a single shared 8-bit MAC and ReLU stage replaces one hardwired node per neuron.
- Receives the layer's activation vector as a stream and buffers it.
- Sequences weight/bias reads from an external synchronous ROM, then streams one ReLU'd 8-bit result per neuron.
- Sits between the previous layer's output stream and the next layer's input stream.

Parameters:
- NUM_INPUTS, 15, activations per neuron (fan-in); range 1..64.
- NUM_NEURONS, 32, neurons in the layer; range 1..256.
- ROM_AW, 10, weight ROM address width; must satisfy NUM_NEURONS*(NUM_INPUTS+1) <= 2**ROM_AW.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low; all state cleared while low.
- act_valid  input  1  activation beat valid.
- act_data  input  8  signed activation.
- act_ready  output  1  high only in LOAD.
- w_rd_en  output  1  ROM read strobe.
- w_addr  output  ROM_AW  ROM address.
- w_data  input  8  signed ROM data, valid the cycle after w_rd_en.
- out_valid  output  1  result valid.
- out_data  output  8  ReLU result; unsigned, 0..127.
- out_idx  output  8  neuron index of out_data.
- out_ready  input  1  downstream accept.
- busy  output  1  high in any state except LOAD with zero activations buffered.
- layer_done  output  1  one-cycle pulse when the last neuron's result is accepted.

Behaviour:
- Reset values:
  - State = LOAD.
  - act_ready=1 once reset deasserts; all other outputs 0.
  - Activation buffer, accumulator and counters all 0.
- Reset asserted mid-operation aborts immediately. No partial result is emitted after release.
- ROM layout: neuron n occupies a row at address n*(NUM_INPUTS+1)+k.
  - k = 0..NUM_INPUTS-1 holds weights.
  - k = NUM_INPUTS holds the bias.
- LOAD state:
  - act_ready=1; each act_valid&&act_ready beat writes buf[cnt] and increments cnt.
  - On the beat with cnt==NUM_INPUTS-1: go to FETCH, clear neuron index n and the accumulator.
- FETCH state:
  - w_rd_en=1 for NUM_INPUTS+1 consecutive cycles, with k = 0..NUM_INPUTS.
  - The cycle after issuing k, w_data is consumed:
    - k < NUM_INPUTS: acc <= acc + low8(buf[k]*w_data).
    - k == NUM_INPUTS: acc <= acc + w_data.
  - After the bias issue cycle comes one DRAIN cycle that consumes the bias. Then go to EMIT.
  - Latency from FETCH entry to out_valid = NUM_INPUTS+2 cycles.
- Arithmetic:
  - Product is the signed 8x8 product truncated to its low 8 bits.
  - Accumulation is 8-bit two's-complement with wrap-around.
- EMIT state:
  - out_data = acc[7] ? 0 : acc; out_idx = n; out_valid=1.
  - out_data and out_idx are held stable until out_ready.
  - On the handshake: if n==NUM_NEURONS-1, pulse layer_done and go to LOAD with cnt=0. Otherwise n++, clear acc, go to FETCH.
- Backpressure: out_ready low holds EMIT indefinitely. No ROM reads are issued while in EMIT.
- act_valid outside LOAD is ignored (act_ready=0). The next vector is accepted only after layer_done.
- Simultaneous layer_done and act_valid: the beat is not accepted that cycle. Acceptance starts the following cycle.
- ROM data arriving after reset assertion is discarded.

Optional Feature:
- SAT_ACC_EN.
- Defined:
  - Each product saturates to [-128,127] instead of truncating.
  - Each accumulator add, including the bias add, saturates to [-128,127].
- Undefined: wrap-around arithmetic as in Behaviour.
- Timing and handshakes are identical in both builds.

Test Plan:
- Basic layer. Setup: NUM_INPUTS=3, NUM_NEURONS=2; row0 weights {1,2,3}, bias 4; row1 weights {-1,0,0}, bias 0; activations {1,1,1}.
  Required: outputs (idx0, 10) then (idx1, 0); layer_done pulses once; each out_valid appears 5 cycles after FETCH entry.
- Wrap. Setup: activation 100, weight 2, bias 0, NUM_INPUTS=1.
  Required without SAT_ACC_EN: out_data 0 (200 wraps to -56, ReLU gives 0). Required with SAT_ACC_EN: 127.
- Backpressure: out_ready held low 10 cycles during neuron 0.
  Required: out_valid/out_data/out_idx stable throughout; w_rd_en stays 0; result 10 accepted on release.
- Activation stall: act_valid gaps between beats.
  Required: only handshaken beats are counted; FETCH starts after the 3rd accepted beat.
- Reset mid-FETCH: reset low for 1 cycle during k=1.
  Required: all outputs 0 immediately; act_ready=1 after release; a fresh vector produces correct results with no stale output.
- Back-to-back layers: a second vector is offered during the layer_done cycle.
  Required: accepted starting the next cycle; results are correct for the new vector.
